// File: rtl/sender.sv
// Switch output stage: pops flits from a FWFT FIFO, XY-routes each packet on its head
// flit and drives one of PORTS_NUM+1 output links with a valid/ack handshake.
module sender #(
    parameter int                      DATA_SIZE = 32,
    parameter int                      ADDR_SIZE = 4,
    parameter int                      PORTS_NUM = 4,
    parameter int                      BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1,
    parameter logic [ADDR_SIZE-1:0]    NODE_ADDR = '0
) (
    input  logic                              clk,
    input  logic                              a_rst_n,
    input  logic                              is_empty,
    input  logic [BUS_SIZE-1:0]               data_i,
    output logic                              rd_req,
    input  logic [PORTS_NUM:0]                r_ready_in,
    output logic [PORTS_NUM:0]                wr_ready_out,
    output logic [(PORTS_NUM+1)*BUS_SIZE-1:0] data_o
);

    localparam int XW = ADDR_SIZE / 2;
    localparam int YW = ADDR_SIZE - XW;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'(PORTS_NUM);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [2:0]          out_port;
    logic                locked;
    logic [BUS_SIZE-1:0] flit;
    logic [2:0]          head_port;

    function automatic logic [2:0] xy_route(input logic [ADDR_SIZE-1:0] dst);
        logic [XW-1:0] dx, nx;
        logic [YW-1:0] dy, ny;
        dx = dst[XW-1:0];
        nx = NODE_ADDR[XW-1:0];
        dy = dst[ADDR_SIZE-1:XW];
        ny = NODE_ADDR[ADDR_SIZE-1:XW];
        if (dx > nx)      xy_route = PORT_E;
        else if (dx < nx) xy_route = PORT_W;
        else if (dy > ny) xy_route = PORT_N;
        else if (dy < ny) xy_route = PORT_S;
        else              xy_route = PORT_L;
    endfunction

    function automatic logic [PORTS_NUM:0] onehot(input logic [2:0] p);
        onehot = '0;
        for (int i = 0; i <= PORTS_NUM; i++)
            onehot[i] = (3'(i) == p);
    endfunction

    function automatic logic [(PORTS_NUM+1)*BUS_SIZE-1:0] spread(input logic [2:0] p,
                                                                 input logic [BUS_SIZE-1:0] f);
        spread = '0;
        for (int i = 0; i <= PORTS_NUM; i++)
            if (3'(i) == p) spread[i*BUS_SIZE +: BUS_SIZE] = f;
    endfunction

    // Only a head flit picks a port; body flits inherit the locked one.
    assign head_port = locked ? out_port : xy_route(data_i[ADDR_SIZE-1:0]);

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state        <= IDLE;
            out_port     <= '0;
            locked       <= 1'b0;
            flit         <= '0;
            rd_req       <= 1'b0;
            wr_ready_out <= '0;
            data_o       <= '0;
        end else begin
            rd_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (!is_empty) begin
                        flit         <= data_i;
                        out_port     <= head_port;
                        locked       <= 1'b1;
                        rd_req       <= 1'b1;
                        wr_ready_out <= onehot(head_port);
                        data_o       <= spread(head_port, data_i);
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (r_ready_in[out_port]) begin
                        // A pop still in flight means data_i shows the flit just acked,
                        // so chaining is only safe once rd_req has dropped.
                        if (!flit[ADDR_SIZE] && !is_empty && !rd_req) begin
                            flit   <= data_i;
                            rd_req <= 1'b1;
                            data_o <= spread(out_port, data_i);
                        end else begin
                            if (flit[ADDR_SIZE]) locked <= 1'b0;
                            wr_ready_out <= '0;
                            data_o       <= '0;
                            state        <= IDLE;
                        end
                    end else begin
                        data_o <= spread(out_port, flit);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
